// File: rtl/sync_join3_if.sv
// rtl/sync_join3_if.sv - three-lane drive/free inputs and joined drive/free output of sync_join3
interface sync_join3_if #(
    parameter int W0 = 5,
    parameter int W1 = 10,
    parameter int W2 = 3
);
    localparam int WO = W0 + W1 + W2;

    logic [2:0]    i_drive_3;
    logic [W0-1:0] i_data0;
    logic [W1-1:0] i_data1;
    logic [W2-1:0] i_data2;
    logic [2:0]    o_free_3;
    logic          o_driveNext;
    logic          i_freeNext;
    logic [WO-1:0] o_data;
    logic          o_err;

    modport slave (
        input  i_drive_3, i_data0, i_data1, i_data2, i_freeNext,
        output o_free_3, o_driveNext, o_data, o_err
    );

    modport master (
        output i_drive_3, i_data0, i_data1, i_data2, i_freeNext,
        input  o_free_3, o_driveNext, o_data, o_err
    );
endinterface

// File: rtl/sync_join3.sv
// rtl/sync_join3.sv - three-lane credit-based join, lane 0 in the MSBs of the joined word
// Optional macro SYNC_JOIN3_ERR_EN compiles in overflow / spurious-free detection on o_err.
module sync_join3 #(
    parameter int DATA_WIDTHIN0 = 5,
    parameter int DATA_WIDTHIN1 = 10,
    parameter int DATA_WIDTHIN2 = 3,
    parameter int FIFO_DEPTH    = 2
) (
    input logic         clk,
    input logic         rst,
    sync_join3_if.slave bus
);
    localparam int W  = DATA_WIDTHIN0 + DATA_WIDTHIN1 + DATA_WIDTHIN2;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTHIN0-1:0] mem0_q [FIFO_DEPTH];
    logic [DATA_WIDTHIN1-1:0] mem1_q [FIFO_DEPTH];
    logic [DATA_WIDTHIN2-1:0] mem2_q [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr_q [3];
    logic [PW-1:0] wr_ptr_d [3];
    logic [PW-1:0] rd_ptr_q [3];
    logic [PW-1:0] rd_ptr_d [3];
    logic [PW-1:0] cnt_q    [3];
    logic [PW-1:0] cnt_d    [3];

    logic [2:0]    full;
    logic [2:0]    push;
    logic          join_go;
    logic [W-1:0]  data_q, data_d;
    logic          drive_next_q;
    logic [2:0]    free_q;

    always_comb begin
        full     = '0;
        push     = '0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        for (int k = 0; k < 3; k++) begin
            full[k] = (cnt_q[k] == PW'(FIFO_DEPTH));
        end
        // Fullness is judged before any same-cycle pop: strict credit accounting.
        push = bus.i_drive_3 & ~full;

        join_go = (cnt_q[0] != '0) && (cnt_q[1] != '0) && (cnt_q[2] != '0) &&
                  ((state_q == IDLE) || bus.i_freeNext);

        for (int k = 0; k < 3; k++) begin
            wr_ptr_d[k] = (wr_ptr_q[k] + PW'(push[k])) & PW'(FIFO_DEPTH - 1);
            rd_ptr_d[k] = (rd_ptr_q[k] + PW'(join_go)) & PW'(FIFO_DEPTH - 1);
            cnt_d[k]    = cnt_q[k] + PW'(push[k]) - PW'(join_go);
        end

        state_d = state_q;
        if (join_go) begin
            state_d = HOLD;
        end else if ((state_q == HOLD) && bus.i_freeNext) begin
            state_d = IDLE;
        end

        data_d = data_q;
        if (join_go) begin
            data_d = {mem0_q[rd_ptr_q[0][AW-1:0]],
                      mem1_q[rd_ptr_q[1][AW-1:0]],
                      mem2_q[rd_ptr_q[2][AW-1:0]]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            data_q       <= '0;
            drive_next_q <= 1'b0;
            free_q       <= '0;
            for (int k = 0; k < 3; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            drive_next_q <= join_go;
            free_q       <= {3{join_go}};
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
        end
    end

    // Storage needs no reset: pointers and counts alone decide what is live.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push[0]) mem0_q[wr_ptr_q[0][AW-1:0]] <= bus.i_data0;
            if (push[1]) mem1_q[wr_ptr_q[1][AW-1:0]] <= bus.i_data1;
            if (push[2]) mem2_q[wr_ptr_q[2][AW-1:0]] <= bus.i_data2;
        end
    end

`ifdef SYNC_JOIN3_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (|(bus.i_drive_3 & full)) | ((state_q == IDLE) && bus.i_freeNext);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.o_err = err_q;
`else
    assign bus.o_err = 1'b0;
`endif

    assign bus.o_data      = data_q;
    assign bus.o_driveNext = drive_next_q;
    assign bus.o_free_3    = free_q;
endmodule

// File: tb/tb_sync_join3.sv
// tb/tb_sync_join3.sv - scoreboard bench for sync_join3 against a queue-level reference model
module tb_sync_join3;
    localparam int D0    = 5;
    localparam int D1    = 10;
    localparam int D2    = 3;
    localparam int DEPTH = 2;
    localparam int W     = D0 + D1 + D2;

    typedef struct {
        logic [W-1:0] word;
        int           edge_n;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sync_join3_if #(.W0(D0), .W1(D1), .W2(D2)) bus ();

    sync_join3 #(
        .DATA_WIDTHIN0(D0),
        .DATA_WIDTHIN1(D1),
        .DATA_WIDTHIN2(D2),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    bit started  = 0;

    logic [D0-1:0] mq0 [$];
    logic [D1-1:0] mq1 [$];
    logic [D2-1:0] mq2 [$];
    exp_t          exp_q [$];
    bit            outst = 0;
    bit            m_err = 0;
    bit            just_joined = 0;
    logic [W-1:0]  m_last = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic bit exp_err();
`ifdef SYNC_JOIN3_ERR_EN
        return m_err;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_edge(input logic [2:0] drv, input logic [D0-1:0] a, input logic [D1-1:0] b,
                              input logic [D2-1:0] c, input logic fr, input logic r);
        bit jn;
        bit f0, f1, f2;
        logic [D0-1:0] h0;
        logic [D1-1:0] h1;
        logic [D2-1:0] h2;
        if (r) begin
            mq0.delete(); mq1.delete(); mq2.delete(); exp_q.delete();
            outst = 0; m_err = 0; m_last = '0; just_joined = 0;
            return;
        end
        jn = (mq0.size() > 0) && (mq1.size() > 0) && (mq2.size() > 0) && (!outst || fr);
        if (fr && !outst) m_err = 1;
        f0 = (mq0.size() == DEPTH);
        f1 = (mq1.size() == DEPTH);
        f2 = (mq2.size() == DEPTH);
        if ((drv[0] && f0) || (drv[1] && f1) || (drv[2] && f2)) m_err = 1;
        if (jn) begin
            h0 = mq0.pop_front();
            h1 = mq1.pop_front();
            h2 = mq2.pop_front();
            m_last = {h0, h1, h2};
            exp_q.push_back('{m_last, edge_n});
            outst = 1;
        end else if (outst && fr) begin
            outst = 0;
        end
        if (drv[0] && !f0) mq0.push_back(a);
        if (drv[1] && !f1) mq1.push_back(b);
        if (drv[2] && !f2) mq2.push_back(c);
        just_joined = jn;
    endtask

    task automatic step(input logic [2:0] drv, input logic [D0-1:0] a, input logic [D1-1:0] b,
                        input logic [D2-1:0] c, input logic fr, input logic r);
        bus.i_drive_3  = drv;
        bus.i_data0    = a;
        bus.i_data1    = b;
        bus.i_data2    = c;
        bus.i_freeNext = fr;
        rst            = r;
        @(posedge clk);
        edge_n++;
        model_edge(drv, a, b, c, fr, r);
        started = 1;
        #1;
    endtask

    task automatic idle(input int n, input logic fr);
        for (int i = 0; i < n; i++) step(3'b000, '0, '0, '0, fr, 1'b0);
    endtask

    task automatic check_zero(input string name);
        check({name, "_free"},  32'(bus.o_free_3), 32'd0);
        check({name, "_drive"}, 32'(bus.o_driveNext), 32'd0);
        check({name, "_data"},  32'(bus.o_data), 32'd0);
        check({name, "_err"},   32'(bus.o_err), 32'd0);
    endtask

    always @(negedge clk) begin
        if (started) begin
            if (exp_q.size() > 0 && exp_q[0].edge_n < edge_n) begin
                check("missing_word", 32'(exp_q[0].edge_n), 32'(edge_n));
                void'(exp_q.pop_front());
            end
            if (bus.o_driveNext || bus.o_free_3 != 3'b000) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(bus.o_driveNext), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("word_data",  32'(bus.o_data), 32'(e.word));
                    check("word_edge",  32'(edge_n), 32'(e.edge_n));
                    check("word_drive", 32'(bus.o_driveNext), 32'd1);
                    check("word_free",  32'(bus.o_free_3), 32'd7);
                end
            end
            check("data_hold", 32'(bus.o_data), 32'(m_last));
            check("err_flag",  32'(bus.o_err), 32'(exp_err()));
        end
    end

    initial begin
        logic [2:0] drv;
        logic       fr;
        bus.i_drive_3  = '0;
        bus.i_data0    = '0;
        bus.i_data1    = '0;
        bus.i_data2    = '0;
        bus.i_freeNext = 1'b0;

        // reset state
        step(3'b000, '0, '0, '0, 1'b0, 1'b1);
        step(3'b000, '0, '0, '0, 1'b0, 1'b1);
        check_zero("reset");

        // simultaneous push, no free: single pulse, then word held
        step(3'b111, 5'h1A, 10'h2F3, 3'h5, 1'b0, 1'b0);
        check("simul_not_yet", 32'(bus.o_driveNext), 32'd0);
        step(3'b000, '0, '0, '0, 1'b0, 1'b0);
        check("simul_pulse", 32'(bus.o_driveNext), 32'd1);
        check("simul_data", 32'(bus.o_data), 32'({5'h1A, 10'h2F3, 3'h5}));
        idle(4, 1'b0);
        check("simul_single", 32'(bus.o_driveNext), 32'd0);
        idle(1, 1'b1);

        // staggered arrival: lane2 at 0, lane0 at 3, lane1 at 7
        for (int cy = 0; cy < 10; cy++) begin
            drv = 3'b000;
            if (cy == 0) drv = 3'b100;
            if (cy == 3) drv = 3'b001;
            if (cy == 7) drv = 3'b010;
            step(drv, 5'h03, 10'h155, 3'h6, 1'b0, 1'b0);
            if (cy == 7) check("stagger_not_yet", 32'(bus.o_driveNext), 32'd0);
            if (cy == 8) check("stagger_pulse", 32'(bus.o_driveNext), 32'd1);
        end
        idle(1, 1'b1);

        // overflow on lane 0
        step(3'b000, '0, '0, '0, 1'b0, 1'b1);
        step(3'b001, 5'h11, '0, '0, 1'b0, 1'b0);
        step(3'b001, 5'h12, '0, '0, 1'b0, 1'b0);
        check("ovf_before", 32'(bus.o_err), 32'd0);
        step(3'b001, 5'h13, '0, '0, 1'b0, 1'b0);
        check("ovf_err", 32'(bus.o_err), 32'(exp_err()));
        step(3'b110, '0, 10'h001, 3'h1, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(3'b110, '0, 10'h002, 3'h2, 1'b1, 1'b0);
        idle(3, 1'b0);
        step(3'b000, '0, '0, '0, 1'b1, 1'b0);
        idle(3, 1'b0);

        // two preloaded sets drained back-to-back
        step(3'b000, '0, '0, '0, 1'b0, 1'b1);
        step(3'b111, 5'h0A, 10'h0AA, 3'h2, 1'b0, 1'b0);
        step(3'b111, 5'h15, 10'h355, 3'h5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(3'b000, '0, '0, '0, just_joined, 1'b0);
        check("b2b_err", 32'(bus.o_err), 32'd0);

        // spurious free in IDLE
        step(3'b000, '0, '0, '0, 1'b1, 1'b0);
        check("spur_err", 32'(bus.o_err), 32'(exp_err()));
        check("spur_drive", 32'(bus.o_driveNext), 32'd0);

        // reset while HOLD with one set buffered
        step(3'b000, '0, '0, '0, 1'b0, 1'b1);
        step(3'b111, 5'h01, 10'h101, 3'h1, 1'b0, 1'b0);
        step(3'b111, 5'h02, 10'h202, 3'h2, 1'b0, 1'b0);
        step(3'b000, '0, '0, '0, 1'b0, 1'b1);
        check_zero("midrst");
        step(3'b111, 5'h1F, 10'h3C3, 3'h7, 1'b0, 1'b0);
        idle(3, 1'b0);
        check("midrst_new", 32'(bus.o_data), 32'({5'h1F, 10'h3C3, 3'h7}));
        idle(1, 1'b1);

        // randomized traffic
        step(3'b000, '0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 2000; i++) begin
            drv = 3'b000;
            if ($urandom_range(0, 9) < 4 && (mq0.size() < DEPTH || $urandom_range(0, 15) == 0)) drv[0] = 1'b1;
            if ($urandom_range(0, 9) < 4 && (mq1.size() < DEPTH || $urandom_range(0, 15) == 0)) drv[1] = 1'b1;
            if ($urandom_range(0, 9) < 4 && (mq2.size() < DEPTH || $urandom_range(0, 15) == 0)) drv[2] = 1'b1;
            if (outst) fr = ($urandom_range(0, 2) != 0);
            else       fr = ($urandom_range(0, 63) == 0);
            step(drv, D0'($urandom), D1'($urandom), D2'($urandom), fr, ($urandom_range(0, 299) == 0));
        end

        idle(6, 1'b1);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
